// File: rtl/ws_mem_pkg.sv
// Shared types and elaboration helpers for the wait-state memory.
package ws_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int STATE_W = 2;

   function automatic int lanes(input int dw);
      return dw / 8;
   endfunction

   // Ceiling log2; returns 0 for v <= 1, so callers clamp to a 1-bit minimum.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/ws_mem_if.sv
// Request/acknowledge bus between a requester (master) and ws_mem (slave).
// REQ is held by the master until the one-cycle ACK pulse; RDATA/ERR are valid while ACK=1.
interface ws_mem_if #(
   parameter int DW = 16,
   parameter int AW = 16
);
   logic            REQ;
   logic            WE;
   logic [AW-1:0]   ADDR;
   logic [DW-1:0]   WDATA;
   logic [DW/8-1:0] BE;
   logic [DW-1:0]   RDATA;
   logic            ACK;
   logic            ERR;
   logic            BUSY;
   logic [DW-1:0]   WATCH;
   logic [1:0]      STATE;

   modport master (
      output REQ, WE, ADDR, WDATA, BE,
      input  RDATA, ACK, ERR, BUSY, WATCH, STATE
   );

   modport slave (
      input  REQ, WE, ADDR, WDATA, BE,
      output RDATA, ACK, ERR, BUSY, WATCH, STATE
   );
endinterface

// File: rtl/ws_mem_waitctr.sv
// Loadable down-counter that stops at zero and flags it.
module ws_mem_waitctr #(
   parameter int W = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ws_mem.sv
// Single-port word RAM behind a REQ/ACK handshake with programmable wait states,
// byte-lane writes, out-of-range error reporting and a fixed-address watch port.
module ws_mem
   import ws_mem_pkg::*;
#(
   parameter int            DW          = 16,
   parameter int            AW          = 16,
   parameter int            DEPTH       = 2048,
   parameter int            WAIT_STATES = 2,
   parameter logic [AW-1:0] WATCH_ADDR  = 16'h05AA
) (
   input logic     CLK,
   input logic     RST,
   ws_mem_if.slave bus
);

   localparam int NL     = lanes(DW);
   localparam int CW_RAW = clog2(WAIT_STATES + 1);
   localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
   localparam int IW_RAW = clog2(DEPTH);
   localparam int IW     = (IW_RAW < 1) ? 1 : IW_RAW;

   localparam logic [CW-1:0] CTR_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

   localparam logic [STATE_W-1:0] S_IDLE = ST_IDLE;
   localparam logic [STATE_W-1:0] S_WAIT = ST_WAIT;
   localparam logic [STATE_W-1:0] S_RESP = ST_RESP;

   if ((WAIT_STATES < 0) || (WAIT_STATES > 255) || ((DW % 8) != 0) || (DW < 8) ||
       (DEPTH < 1) || (64'(DEPTH) > (64'd1 << AW))) begin : g_bad_param
      $error("ws_mem: illegal parameter set (WAIT_STATES 0..255, DW multiple of 8, DEPTH <= 2**AW)");
   end

   logic [STATE_W-1:0] state_q, state_d;
   logic               we_q, we_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [DW-1:0]      wdata_q, wdata_d;
   logic [NL-1:0]      be_q, be_d;
   logic [DW-1:0]      rdata_q, rdata_d;
   logic               err_q, err_d;

   logic               ctr_load;
   logic               ctr_dec;
   logic               ctr_zero;

   logic               to_resp;
   logic               acc_we;
   logic [AW-1:0]      acc_addr;
   logic [DW-1:0]      acc_wdata;
   logic [NL-1:0]      acc_be;
   logic [IW-1:0]      acc_idx;
   logic               acc_in_range;
   logic [DW-1:0]      mem_word;
   logic [DW-1:0]      merged;

   logic [DW-1:0]      mem [DEPTH];

   ws_mem_waitctr #(
      .W (CW)
   ) u_waitctr (
      .clk_i      (CLK),
      .rst_i      (RST),
      .load_i     (ctr_load),
      .load_val_i (CTR_LOAD),
      .dec_i      (ctr_dec),
      .zero_o     (ctr_zero)
   );

   // With no wait states the access happens on the accept edge, so the live bus is used directly.
   always_comb begin
      if (state_q == S_IDLE) begin
         acc_we    = bus.WE;
         acc_addr  = bus.ADDR;
         acc_wdata = bus.WDATA;
         acc_be    = bus.BE;
      end else begin
         acc_we    = we_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_be    = be_q;
      end
   end

   assign acc_in_range = ({1'b0, acc_addr} < (AW + 1)'(DEPTH));
   assign acc_idx      = acc_addr[IW-1:0];
   assign mem_word     = mem[acc_idx];

   always_comb begin
      merged = mem_word;
      for (int i = 0; i < NL; i++) begin
         if (acc_be[i]) merged[8*i +: 8] = acc_wdata[8*i +: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      ctr_load = 1'b0;
      ctr_dec  = 1'b0;
      to_resp  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.REQ) begin
               we_d    = bus.WE;
               addr_d  = bus.ADDR;
               wdata_d = bus.WDATA;
               be_d    = bus.BE;
               if (WAIT_STATES == 0) begin
                  state_d = S_RESP;
                  to_resp = 1'b1;
               end else begin
                  state_d  = S_WAIT;
                  ctr_load = 1'b1;
               end
            end
         end
         S_WAIT: begin
            ctr_dec = 1'b1;
            if (ctr_zero) begin
               state_d = S_RESP;
               to_resp = 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Writes and out-of-range accesses both return zero data.
      if (to_resp) begin
         err_d   = !acc_in_range;
         rdata_d = (!acc_we && acc_in_range) ? mem_word : '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array contents survive reset; an aborted access never reaches this edge because state_q clears first.
   always_ff @(posedge CLK) begin
      if (to_resp && acc_we && acc_in_range) begin
         mem[acc_idx] <= merged;
      end
   end

   if (int'(WATCH_ADDR) < DEPTH) begin : g_watch
      assign bus.WATCH = mem[WATCH_ADDR[IW-1:0]];
   end else begin : g_no_watch
      assign bus.WATCH = '0;
   end

   assign bus.RDATA = rdata_q;
   assign bus.ACK   = (state_q == S_RESP);
   assign bus.ERR   = err_q;
   assign bus.BUSY  = (state_q != S_IDLE);
   assign bus.STATE = state_q;

endmodule

// File: tb/tb_ws_mem.sv
// Scoreboard bench for ws_mem: a two-wait-state instance and a zero-wait-state instance.
module tb_ws_mem;
   import ws_mem_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   always #5 CLK = ~CLK;

   ws_mem_if #(.DW(16), .AW(16)) bus  ();
   ws_mem_if #(.DW(16), .AW(16)) bus0 ();

   ws_mem #(
      .DW(16), .AW(16), .DEPTH(2048), .WAIT_STATES(2), .WATCH_ADDR(16'h05AA)
   ) u_dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   ws_mem #(
      .DW(16), .AW(16), .DEPTH(2048), .WAIT_STATES(0), .WATCH_ADDR(16'h05AA)
   ) u_dut0 (
      .CLK (CLK),
      .RST (RST),
      .bus (bus0)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   logic [15:0] exp_q[$];
   logic        exp_err_q[$];
   logic [15:0] model_mem [0:2047];

   // Reference memory: returns expected RDATA and ERR, applies writes to the model.
   function automatic logic [15:0] model_access(input logic we, input logic [15:0] addr,
                                                input logic [15:0] wdata, input logic [1:0] be,
                                                output logic err);
      logic [15:0] r;
      r   = 16'h0000;
      err = (addr >= 16'h0800);
      if (!err) begin
         if (we) begin
            for (int i = 0; i < 2; i++) begin
               if (be[i]) model_mem[addr[10:0]][8*i +: 8] = wdata[8*i +: 8];
            end
         end else begin
            r = model_mem[addr[10:0]];
         end
      end
      return r;
   endfunction

   task automatic push_exp(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be);
      logic [15:0] r;
      logic        e;
      r = model_access(we, addr, wdata, be, e);
      exp_q.push_back(r);
      exp_err_q.push_back(e);
   endtask

   // Drives one request on the wait-state DUT, scrambles the bus after acceptance, waits for ACK.
   task automatic drive_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [1:0] be, output int lat, output logic [15:0] rd,
                               output logic err, output logic [15:0] watch);
      @(posedge CLK); #1;
      bus.REQ = 1'b1; bus.WE = we; bus.ADDR = addr; bus.WDATA = wdata; bus.BE = be;
      lat = -1; rd = '0; err = 1'b0; watch = '0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge CLK); #1;
         if (c == 1) begin
            bus.WE    = 1'($urandom_range(0, 1));
            bus.ADDR  = 16'($urandom_range(0, 65535));
            bus.WDATA = 16'($urandom_range(0, 65535));
            bus.BE    = 2'($urandom_range(0, 3));
         end
         if (bus.ACK) begin
            lat = c; rd = bus.RDATA; err = bus.ERR; watch = bus.WATCH;
            break;
         end
      end
      bus.REQ = 1'b0;
   endtask

   task automatic drive_access0(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [1:0] be, output int lat, output logic [15:0] rd,
                                output logic err, output logic saw_wait);
      @(posedge CLK); #1;
      bus0.REQ = 1'b1; bus0.WE = we; bus0.ADDR = addr; bus0.WDATA = wdata; bus0.BE = be;
      lat = -1; rd = '0; err = 1'b0; saw_wait = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge CLK); #1;
         if (bus0.STATE == ST_WAIT) saw_wait = 1'b1;
         if (bus0.ACK) begin
            lat = c; rd = bus0.RDATA; err = bus0.ERR;
            break;
         end
      end
      bus0.REQ = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      #1;
      tests_run++;
      if ({bus.ACK, bus.BUSY, bus.ERR} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got ack/busy/err=%b required 000", {bus.ACK, bus.BUSY, bus.ERR});
      end
      tests_run++;
      if (bus.RDATA !== 16'h0000) begin
         tests_failed++;
         $display("FAIL reset_rdata: got %h required 0000", bus.RDATA);
      end
      tests_run++;
      if (bus.STATE !== ST_IDLE) begin
         tests_failed++;
         $display("FAIL reset_state: got %0d required %0d", bus.STATE, ST_IDLE);
      end
      tests_run++;
      if ({bus0.ACK, bus0.BUSY, bus0.ERR} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_ctrl0: got ack/busy/err=%b required 000", {bus0.ACK, bus0.BUSY, bus0.ERR});
      end
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_write_read;
      int lat; logic [15:0] rd, wt, er_d; logic err;
      push_exp(1'b1, 16'h05AA, 16'h2910, 2'b11);
      drive_access(1'b1, 16'h05AA, 16'h2910, 2'b11, lat, rd, err, wt);
      er_d = exp_q.pop_front();
      tests_run++;
      if (lat != 3) begin tests_failed++; $display("FAIL wr_latency: got %0d required 3", lat); end
      tests_run++;
      if (rd !== er_d) begin tests_failed++; $display("FAIL wr_rdata: got %h required %h", rd, er_d); end
      tests_run++;
      if (err !== exp_err_q.pop_front()) begin tests_failed++; $display("FAIL wr_err: got %b", err); end
      tests_run++;
      if (wt !== 16'h2910) begin tests_failed++; $display("FAIL wr_watch: got %h required 2910", wt); end

      push_exp(1'b0, 16'h05AA, 16'h0000, 2'b00);
      drive_access(1'b0, 16'h05AA, 16'h0000, 2'b00, lat, rd, err, wt);
      er_d = exp_q.pop_front();
      tests_run++;
      if (lat != 3) begin tests_failed++; $display("FAIL rd_latency: got %0d required 3", lat); end
      tests_run++;
      if (rd !== er_d) begin tests_failed++; $display("FAIL rd_data: got %h required %h", rd, er_d); end
      tests_run++;
      if (err !== exp_err_q.pop_front()) begin tests_failed++; $display("FAIL rd_err: got %b", err); end

      @(posedge CLK); #1;
      tests_run++;
      if (bus.ACK !== 1'b0 || bus.RDATA !== 16'h2910) begin
         tests_failed++;
         $display("FAIL rdata_hold: got ack=%b rdata=%h required ack=0 rdata=2910", bus.ACK, bus.RDATA);
      end
   endtask

   task automatic test_byte_lane;
      int lat; logic [15:0] rd, wt, er_d, d; logic err; logic [1:0] be;
      push_exp(1'b1, 16'h05AA, 16'h00FF, 2'b01);
      drive_access(1'b1, 16'h05AA, 16'h00FF, 2'b01, lat, rd, err, wt);
      void'(exp_q.pop_front()); void'(exp_err_q.pop_front());
      tests_run++;
      if (wt !== 16'h29FF) begin tests_failed++; $display("FAIL lane_watch: got %h required 29FF", wt); end

      push_exp(1'b0, 16'h05AA, 16'h0000, 2'b00);
      drive_access(1'b0, 16'h05AA, 16'h0000, 2'b00, lat, rd, err, wt);
      er_d = exp_q.pop_front(); void'(exp_err_q.pop_front());
      tests_run++;
      if (rd !== er_d) begin tests_failed++; $display("FAIL lane_read: got %h required %h", rd, er_d); end

      for (int i = 0; i < 4; i++) begin
         d = 16'($urandom_range(0, 65535));
         push_exp(1'b1, 16'h0100 + 16'(i), d, 2'b11);
         drive_access(1'b1, 16'h0100 + 16'(i), d, 2'b11, lat, rd, err, wt);
         void'(exp_q.pop_front()); void'(exp_err_q.pop_front());
         d  = 16'($urandom_range(0, 65535));
         be = 2'(i);
         push_exp(1'b1, 16'h0100 + 16'(i), d, be);
         drive_access(1'b1, 16'h0100 + 16'(i), d, be, lat, rd, err, wt);
         void'(exp_q.pop_front()); void'(exp_err_q.pop_front());
         push_exp(1'b0, 16'h0100 + 16'(i), 16'h0000, 2'b11);
         drive_access(1'b0, 16'h0100 + 16'(i), 16'h0000, 2'b11, lat, rd, err, wt);
         er_d = exp_q.pop_front(); void'(exp_err_q.pop_front());
         tests_run++;
         if (rd !== er_d) begin
            tests_failed++;
            $display("FAIL lane_rand be=%b: got %h required %h", be, rd, er_d);
         end
      end
   endtask

   task automatic test_out_of_range;
      int lat; logic [15:0] rd, wt, er_d; logic err, ee;
      push_exp(1'b1, 16'h0000, 16'h1111, 2'b11);
      drive_access(1'b1, 16'h0000, 16'h1111, 2'b11, lat, rd, err, wt);
      void'(exp_q.pop_front()); void'(exp_err_q.pop_front());

      push_exp(1'b0, 16'h0800, 16'h0000, 2'b11);
      drive_access(1'b0, 16'h0800, 16'h0000, 2'b11, lat, rd, err, wt);
      er_d = exp_q.pop_front(); ee = exp_err_q.pop_front();
      tests_run++;
      if (err !== ee || rd !== er_d || lat != 3) begin
         tests_failed++;
         $display("FAIL oor_read: got err=%b rd=%h lat=%0d required err=%b rd=%h lat=3", err, rd, lat, ee, er_d);
      end

      push_exp(1'b1, 16'h0800, 16'hDEAD, 2'b11);
      drive_access(1'b1, 16'h0800, 16'hDEAD, 2'b11, lat, rd, err, wt);
      er_d = exp_q.pop_front(); ee = exp_err_q.pop_front();
      tests_run++;
      if (err !== ee || rd !== er_d) begin
         tests_failed++;
         $display("FAIL oor_write: got err=%b rd=%h required err=%b rd=%h", err, rd, ee, er_d);
      end
      tests_run++;
      if (wt !== 16'h29FF) begin tests_failed++; $display("FAIL oor_watch: got %h required 29FF", wt); end

      push_exp(1'b0, 16'h0000, 16'h0000, 2'b00);
      drive_access(1'b0, 16'h0000, 16'h0000, 2'b00, lat, rd, err, wt);
      er_d = exp_q.pop_front(); void'(exp_err_q.pop_front());
      tests_run++;
      if (rd !== er_d) begin tests_failed++; $display("FAIL oor_alias: got %h required %h", rd, er_d); end
   endtask

   task automatic test_reset_mid_op;
      int lat; logic [15:0] rd, wt, er_d; logic err;
      push_exp(1'b1, 16'h0010, 16'hBEEF, 2'b11);
      drive_access(1'b1, 16'h0010, 16'hBEEF, 2'b11, lat, rd, err, wt);
      void'(exp_q.pop_front()); void'(exp_err_q.pop_front());
      push_exp(1'b0, 16'h05AA, 16'h0000, 2'b00);
      drive_access(1'b0, 16'h05AA, 16'h0000, 2'b00, lat, rd, err, wt);
      void'(exp_q.pop_front()); void'(exp_err_q.pop_front());

      @(posedge CLK); #1;
      bus.REQ = 1'b1; bus.WE = 1'b1; bus.ADDR = 16'h0010; bus.WDATA = 16'h1234; bus.BE = 2'b11;
      @(posedge CLK); #1;
      tests_run++;
      if (bus.BUSY !== 1'b1) begin tests_failed++; $display("FAIL mid_busy: got %b required 1", bus.BUSY); end
      #2 RST = 1'b1;
      #1;
      tests_run++;
      if ({bus.ACK, bus.BUSY} !== 2'b00 || bus.RDATA !== 16'h0000) begin
         tests_failed++;
         $display("FAIL mid_reset: got ack=%b busy=%b rdata=%h required 0 0 0000", bus.ACK, bus.BUSY, bus.RDATA);
      end
      bus.REQ = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;

      push_exp(1'b0, 16'h0010, 16'h0000, 2'b00);
      drive_access(1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd, err, wt);
      er_d = exp_q.pop_front(); void'(exp_err_q.pop_front());
      tests_run++;
      if (rd !== er_d) begin tests_failed++; $display("FAIL mid_aborted: got %h required %h", rd, er_d); end
   endtask

   task automatic test_back_to_back;
      int lat, n_ack, a1, a2, idle_cnt; logic [15:0] rd, wt, er_d; logic err;
      push_exp(1'b1, 16'h0001, 16'hA001, 2'b11);
      drive_access(1'b1, 16'h0001, 16'hA001, 2'b11, lat, rd, err, wt);
      void'(exp_q.pop_front()); void'(exp_err_q.pop_front());
      push_exp(1'b1, 16'h0002, 16'h5A02, 2'b11);
      drive_access(1'b1, 16'h0002, 16'h5A02, 2'b11, lat, rd, err, wt);
      void'(exp_q.pop_front()); void'(exp_err_q.pop_front());

      push_exp(1'b0, 16'h0001, 16'h0000, 2'b00);
      push_exp(1'b0, 16'h0002, 16'h0000, 2'b00);
      @(posedge CLK); #1;
      bus.REQ = 1'b1; bus.WE = 1'b0; bus.ADDR = 16'h0001; bus.WDATA = 16'h0000; bus.BE = 2'b00;
      n_ack = 0; a1 = 0; a2 = 0; idle_cnt = 0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge CLK); #1;
         if (n_ack == 1 && !bus.BUSY) idle_cnt++;
         if (bus.ACK) begin
            n_ack++;
            er_d = exp_q.pop_front(); void'(exp_err_q.pop_front());
            tests_run++;
            if (bus.RDATA !== er_d) begin
               tests_failed++;
               $display("FAIL b2b_data%0d: got %h required %h", n_ack, bus.RDATA, er_d);
            end
            if (n_ack == 1) begin
               a1 = c;
               bus.ADDR = 16'h0002;
            end else begin
               a2 = c;
               break;
            end
         end
      end
      bus.REQ = 1'b0;
      tests_run++;
      if (n_ack != 2 || (a2 - a1) != 4) begin
         tests_failed++;
         $display("FAIL b2b_spacing: got acks=%0d gap=%0d required acks=2 gap=4", n_ack, a2 - a1);
      end
      tests_run++;
      if (idle_cnt != 1) begin tests_failed++; $display("FAIL b2b_idle: got %0d required 1", idle_cnt); end
   endtask

   task automatic test_random;
      int lat; logic [15:0] rd, wt, er_d, a, d; logic err, ee, we; logic [1:0] be;
      for (int i = 0; i < 10; i++) begin
         we = 1'($urandom_range(0, 1));
         be = 2'($urandom_range(0, 3));
         d  = 16'($urandom_range(0, 65535));
         a  = ($urandom_range(0, 3) == 0) ? 16'h0800 + 16'($urandom_range(0, 3))
                                          : 16'h0100 + 16'($urandom_range(0, 3));
         push_exp(we, a, d, be);
         drive_access(we, a, d, be, lat, rd, err, wt);
         er_d = exp_q.pop_front(); ee = exp_err_q.pop_front();
         tests_run++;
         if (lat != 3 || rd !== er_d || err !== ee) begin
            tests_failed++;
            $display("FAIL rand%0d we=%b a=%h: got lat=%0d rd=%h err=%b required lat=3 rd=%h err=%b",
                     i, we, a, lat, rd, err, er_d, ee);
         end
      end
   endtask

   task automatic test_zero_wait;
      int lat; logic [15:0] rd; logic err, sw;
      drive_access0(1'b1, 16'h0003, 16'hA5A5, 2'b11, lat, rd, err, sw);
      tests_run++;
      if (lat != 1 || sw !== 1'b0 || err !== 1'b0 || rd !== 16'h0000) begin
         tests_failed++;
         $display("FAIL zw_write: got lat=%0d wait=%b err=%b rd=%h required 1 0 0 0000", lat, sw, err, rd);
      end
      drive_access0(1'b0, 16'h0003, 16'h0000, 2'b00, lat, rd, err, sw);
      tests_run++;
      if (lat != 1 || sw !== 1'b0 || rd !== 16'hA5A5) begin
         tests_failed++;
         $display("FAIL zw_read: got lat=%0d wait=%b rd=%h required 1 0 A5A5", lat, sw, rd);
      end
      drive_access0(1'b0, 16'h0900, 16'h0000, 2'b00, lat, rd, err, sw);
      tests_run++;
      if (lat != 1 || err !== 1'b1 || rd !== 16'h0000) begin
         tests_failed++;
         $display("FAIL zw_oor: got lat=%0d err=%b rd=%h required 1 1 0000", lat, err, rd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.REQ  = 1'b0; bus.WE  = 1'b0; bus.ADDR  = '0; bus.WDATA  = '0; bus.BE  = '0;
      bus0.REQ = 1'b0; bus0.WE = 1'b0; bus0.ADDR = '0; bus0.WDATA = '0; bus0.BE = '0;
      test_reset();
      test_write_read();
      test_byte_lane();
      test_out_of_range();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      test_zero_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
